muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Parametrised iterative multiply/divide unit feeding the HI/LO registers of the multicycle datapath. It replaces the separate fixed-width multiplier and divider with one shared engine. The engine takes operands from the A/B registers on a start strobe and returns a HI/LO result with a one-cycle done pulse that the control unit waits on. Signed and (optionally) unsigned multiply and divide are handled with MIPS result semantics.

## Interface
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; minimum 4.
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high; all state cleared on the clock edge where it is high.
- start  in  1  launch request, sampled only in IDLE.
- op  in  2  00 mult, 01 div, 10 multu, 11 divu.
- a  in  WIDTH  multiplicand / dividend (rs).
- b  in  WIDTH  multiplier / divisor (rt).
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; hi/lo/div_zero are valid in this cycle.
- hi  out  WIDTH  product upper half / remainder.
- lo  out  WIDTH  product lower half / quotient.
- div_zero  out  1  last completed operation was a divide with b==0.

## Operation
- Reset value of every output: 0; state IDLE.
- IDLE: on start=1, latch op, a and b; compute magnitudes and result signs; go to PREP.
- PREP (1 cycle):
  - divide with b==0: go to FIX with the zero flag set.
  - otherwise: load the iteration counter with WIDTH and go to RUN.
- RUN (WIDTH cycles, 1 bit per cycle):
  - multiply: shift-add on magnitudes into a 2·WIDTH accumulator.
  - divide: restoring division on magnitudes.
  - go to FIX when the counter reaches 0.
- FIX (1 cycle):
  - apply sign correction and register hi/lo/div_zero.
  - pulse done, drop busy, return to IDLE.
- Signed multiply: full 2·WIDTH two's-complement product; hi = upper WIDTH bits, lo = lower WIDTH bits.
- Signed divide:
  - quotient truncates toward zero (lo); remainder takes the sign of the dividend (hi).
  - MIN / -1 gives lo=MIN, hi=0, with no flag.
- Unsigned ops (op[1]=1): operands are treated as magnitudes and no sign correction is applied.
- Divide by zero: hi and lo keep their previous values; div_zero=1. div_zero is rewritten at every completion.
- start while busy: ignored, with no queueing. Operands must not be changed after they are latched.
- reset mid-operation: abort to IDLE; all outputs return to 0 on that edge.
- hi/lo hold their value between completions.

## Timing
- Define cycle 0 as the cycle in which start=1 is sampled in IDLE.
- busy=1 in cycles 1..WIDTH+1.
- done=1 in cycle WIDTH+2 (34 for WIDTH=32).
- Divide by zero: busy=1 in cycle 1; done=1 in cycle 2.
- The earliest next start is accepted in the done cycle, because the unit is back in IDLE there. That start begins a new cycle 0.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- MULDIV_UNSIGNED_EN defined: op 10/11 perform multu/divu as described.
- MULDIV_UNSIGNED_EN undefined: op[1] is ignored, so 10 behaves as mult and 11 as div. The unsigned-bypass logic is removed.

## Test plan
- Signed multiply: op=00, a=0xFFFFFFFD (-3), b=5 → done in cycle 34, hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high in cycles 1..33.
- Signed divide: op=01, a=7, b=0xFFFFFFFE (-2) → lo=0xFFFFFFFD, hi=0x00000001. Then a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0, div_zero=0.
- Divide by zero: after the previous result, op=01, a=9, b=0 → done in cycle 2, div_zero=1, hi/lo unchanged.
- Unsigned multiply: op=10, a=b=0xFFFFFFFF:
  - with MULDIV_UNSIGNED_EN: hi=0xFFFFFFFE, lo=0x00000001.
  - without it: hi=0, lo=1.
- Start while busy and reset:
  - start pulsed in cycle 10 of a multiply → ignored; the original result arrives in cycle 34.
  - reset in cycle 20 of a second operation → next cycle busy=done=0, hi=lo=0; a new start is accepted immediately.
- WIDTH=8 instance: op=11, a=200, b=7 (macro on) → done in cycle 10, lo=28, hi=4.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative shared multiply/divide engine for HI/LO (MULDIV_UNSIGNED_EN enables multu/divu)
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, PREP, RUN} state_t;
  state_t r_state, w_next;
  logic               r_div, r_qneg, r_rneg, r_done, r_dz;
  logic [WIDTH-1:0]   r_mb, r_hi, r_lo;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic               w_sgn, w_an, w_bn, w_fin, w_dz;
  logic [WIDTH-1:0]   w_ma, w_mb, w_q, w_r;
  logic [WIDTH:0]     w_sum, w_sh, w_diff;
  logic [2*WIDTH-1:0] w_acc_n, w_prod;
`ifdef MULDIV_UNSIGNED_EN
  assign w_sgn = ~op[1];
`else
  logic w_unused;
  assign w_unused = op[1];
  assign w_sgn = 1'b1;
`endif
  assign w_an = w_sgn & a[WIDTH-1];
  assign w_bn = w_sgn & b[WIDTH-1];
  assign w_ma = w_an ? -a : a;
  assign w_mb = w_bn ? -b : b;
  assign w_fin = (r_state == RUN) && (r_cnt == CW'(1));
  assign w_dz = (r_state == PREP) && r_div && (r_mb == '0);
  // the accumulator starts as {0, |a|}: multiply adds |b| into the upper half, divide shifts |a| out as dividend bits
  assign w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_mb : {WIDTH{1'b0}})};
  assign w_sh = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_diff = w_sh - {1'b0, r_mb};
  assign w_acc_n = r_div ? {(w_diff[WIDTH] ? w_sh[WIDTH-1:0] : w_diff[WIDTH-1:0]), r_acc[WIDTH-2:0], ~w_diff[WIDTH]}
                         : {w_sum, r_acc[WIDTH-1:1]};
  assign w_prod = r_qneg ? -w_acc_n : w_acc_n;
  assign w_q = r_qneg ? -w_acc_n[WIDTH-1:0] : w_acc_n[WIDTH-1:0];
  assign w_r = r_rneg ? -w_acc_n[2*WIDTH-1:WIDTH] : w_acc_n[2*WIDTH-1:WIDTH];
  assign busy = (r_state != IDLE);
  assign done = r_done;
  assign hi = r_hi;
  assign lo = r_lo;
  assign div_zero = r_dz;
  // next state: sign fix-up is folded into the final iteration so the unit is idle again in the done cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? PREP : IDLE;
      PREP:    w_next = w_dz ? IDLE : RUN;
      RUN:     w_next = w_fin ? IDLE : RUN;
      default: w_next = IDLE;
    endcase
  end
  // state, operand latch, iteration datapath and registered HI/LO results
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_div   <= 1'b0;
      r_qneg  <= 1'b0;
      r_rneg  <= 1'b0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
      r_mb    <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= w_fin | w_dz;
      if (r_state == IDLE && start) begin
        r_div  <= op[0];
        r_qneg <= w_an ^ w_bn;
        r_rneg <= w_an;
        r_mb   <= w_mb;
        r_acc  <= {{WIDTH{1'b0}}, w_ma};
      end
      if (r_state == PREP) r_cnt <= CW'(WIDTH);
      if (r_state == RUN) begin
        r_acc <= w_acc_n;
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_fin) begin
        r_hi <= r_div ? w_r : w_prod[2*WIDTH-1:WIDTH];
        r_lo <= r_div ? w_q : w_prod[WIDTH-1:0];
        r_dz <= 1'b0;
      end
      if (w_dz) r_dz <= 1'b1;
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit (32-bit and 8-bit instances)
module tb_muldiv_unit;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, start8 = 1'b0;
  logic [1:0]  op = '0, op8 = '0;
  logic [31:0] a = '0, b = '0, hi, lo;
  logic [7:0]  a8 = '0, b8 = '0, hi8, lo8;
  logic        busy, done, dz, busy8, done8, dz8;
  int n_chk = 0, n_fail = 0, dc;

  muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(dz));
  muldiv_unit #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .div_zero(dz8));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // called at a negedge; start is driven in that cycle (cycle 0); returns at the negedge of the done cycle
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int poke, input int abort, output int cyc);
    int bad;
    bad = 0;
    op = o; a = x; b = y; start = 1'b1; cyc = 0;
    @(negedge clk);
    for (int c = 1; c <= 60; c++) begin
      if (done) begin cyc = c; break; end
      if (!busy) bad++;
      start = (c == poke);
      if (c == abort) begin
        reset = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_run", bad, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_dz", dz, 0);
    check("rst8_busy", busy8, 0);
    check("rst8_lo", lo8, 0);
    reset = 1'b0;

    run_op(2'b00, 32'hFFFFFFFD, 32'd5, 0, 0, dc);
    check("mul_cyc", dc, 34);
    check("mul_busy_done", busy, 0);
    check("mul_hi", hi, 32'hFFFFFFFF);
    check("mul_lo", lo, 32'hFFFFFFF1);
    check("mul_dz", dz, 0);

    run_op(2'b00, 32'h80000000, 32'h80000000, 0, 0, dc);
    check("minmin_hi", hi, 32'h40000000);
    check("minmin_lo", lo, 32'h0);

    run_op(2'b00, 32'hFFFFFFF9, 32'hFFFFFFF7, 0, 0, dc);
    check("negneg_hi", hi, 32'h0);
    check("negneg_lo", lo, 32'd63);

    run_op(2'b01, 32'd7, 32'hFFFFFFFE, 0, 0, dc);
    check("div_cyc", dc, 34);
    check("div_lo", lo, 32'hFFFFFFFD);
    check("div_hi", hi, 32'h1);

    run_op(2'b01, 32'hFFFFFFF9, 32'd2, 0, 0, dc);
    check("ndiv_lo", lo, 32'hFFFFFFFD);
    check("ndiv_hi", hi, 32'hFFFFFFFF);

    run_op(2'b01, 32'h80000000, 32'hFFFFFFFF, 0, 0, dc);
    check("ovf_lo", lo, 32'h80000000);
    check("ovf_hi", hi, 32'h0);
    check("ovf_dz", dz, 0);

    run_op(2'b01, 32'd9, 32'd0, 0, 0, dc);
    check("dz_cyc", dc, 2);
    check("dz_flag", dz, 1);
    check("dz_lo", lo, 32'h80000000);
    check("dz_hi", hi, 32'h0);

    run_op(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, dc);
    check("mulu_dz_clr", dz, 0);
`ifdef MULDIV_UNSIGNED_EN
    check("mulu_hi", hi, 32'hFFFFFFFE);
    check("mulu_lo", lo, 32'h00000001);
`else
    check("mulu_hi", hi, 32'h0);
    check("mulu_lo", lo, 32'h1);
`endif

    run_op(2'b00, 32'h00010000, 32'h00010000, 10, 0, dc);
    check("poke_cyc", dc, 34);
    check("poke_hi", hi, 32'h1);
    check("poke_lo", lo, 32'h0);
    @(negedge clk);
    check("poke_noq_busy", busy, 0);
    check("poke_noq_done", done, 0);

    run_op(2'b00, 32'd6, 32'd7, 0, 20, dc);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    reset = 1'b0;
    run_op(2'b00, 32'd6, 32'd7, 0, 0, dc);
    check("restart_cyc", dc, 34);
    check("restart_lo", lo, 32'd42);
    check("restart_hi", hi, 32'd0);

    op8 = 2'b11; a8 = 8'd200; b8 = 8'd7; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    dc = 0;
    for (int c = 1; c <= 30; c++) begin
      if (done8) begin dc = c; break; end
      @(negedge clk);
    end
    check("w8_cyc", dc, 10);
`ifdef MULDIV_UNSIGNED_EN
    check("w8_lo", lo8, 8'd28);
    check("w8_hi", hi8, 8'd4);
`else
    check("w8_lo", lo8, 8'hF8);
    check("w8_hi", hi8, 8'd0);
`endif
    check("w8_dz", dz8, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
